// File: rtl/aes_enc_iter.sv
// aes_enc_iter
//    Iterative AES-128 encryptor. One cipher round is computed per clock and
//    the round keys are derived on the fly, so only the current round key is
//    stored. The last round key of the loaded key is exported so the matching
//    iterative decryptor can start its inverse key schedule from it.
//
// Ports
//    CLK    in   1    system clock, rising edge
//    RSTn   in   1    synchronous active-low reset
//    EN     in   1    global enable, all registers hold while low
//    Din    in   128  plaintext, byte 0 in Din[127:120]
//    Key    in   128  cipher key, same byte order
//    Krdy   in   1    key load request, honoured only while idle
//    Drdy   in   1    encrypt start request, honoured only while idle
//    Dout   out  128  ciphertext register
//    Dvld   out  1    Dout holds a completed ciphertext
//    BSY    out  1    encryption in progress
//    Kout   out  128  round-10 key of the loaded key (0 when KOUT_EN=0)
//    Kvld   out  1    Kout matches the currently loaded key
module aes_enc_iter #(
   parameter bit KOUT_EN = 1'b1
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         EN,
   input  logic [127:0] Din,
   input  logic [127:0] Key,
   input  logic         Krdy,
   input  logic         Drdy,
   output logic [127:0] Dout,
   output logic         Dvld,
   output logic         BSY,
   output logic [127:0] Kout,
   output logic         Kvld
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } stateT;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   stateT        state;
   stateT        nextState;
   logic [127:0] dataReg;
   logic [127:0] keyReg;
   logic [127:0] roundKeyReg;
   logic [127:0] koutReg;
   logic [7:0]   rcon;
   logic [9:0]   roundOneHot;
   logic         dvldReg;
   logic         kvldReg;
   logic         loadKey;
   logic         startEnc;
   logic         stepRound;
   logic         lastRound;
   logic [31:0]  keyTemp;
   logic [31:0]  nextW0;
   logic [31:0]  nextW1;
   logic [31:0]  nextW2;
   logic [31:0]  nextW3;
   logic [127:0] keyNext;
   logic [127:0] subState;
   logic [127:0] shiftState;
   logic [127:0] mixState;
   logic [127:0] roundOut;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   // Multiply by x in GF(2^8), reduction polynomial 0x11b.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // One MixColumns column: each output byte is 2*a ^ 3*b ^ c ^ d with the
   // inputs rotated, where 3*b is written as xtime(b) ^ b.
   function automatic logic [31:0] mixColumn(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Forward key expansion step: the next round key is built from the one
   // held in roundKeyReg using RotWord/SubWord of its last word and the
   // current Rcon, then chained word by word.
   assign keyTemp = {sbox(roundKeyReg[23:16]), sbox(roundKeyReg[15:8]),
                     sbox(roundKeyReg[7:0]),   sbox(roundKeyReg[31:24])} ^ {rcon, 24'h000000};
   assign nextW0  = roundKeyReg[127:96] ^ keyTemp;
   assign nextW1  = roundKeyReg[95:64]  ^ nextW0;
   assign nextW2  = roundKeyReg[63:32]  ^ nextW1;
   assign nextW3  = roundKeyReg[31:0]   ^ nextW2;
   assign keyNext = {nextW0, nextW1, nextW2, nextW3};

   // Round datapath: SubBytes on all sixteen bytes, ShiftRows by moving row r
   // of column c from column (c+r) mod 4, then MixColumns per column. The
   // final round skips MixColumns, selected from the one-hot round counter.
   always_comb begin
      subState   = '0;
      shiftState = '0;
      mixState   = '0;
      for (int i = 0; i < 16; i++) begin
         subState[127-8*i -: 8] = sbox(dataReg[127-8*i -: 8]);
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shiftState[127-8*(4*c+r) -: 8] = subState[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mixState[127-32*c -: 32] = mixColumn(shiftState[127-32*c -: 32]);
      end
   end

   assign roundOut = (roundOneHot[9] ? shiftState : mixState) ^ keyNext;

   // State register. EN low freezes the controller together with the
   // datapath so a stalled encryption resumes exactly where it stopped.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state <= IDLE;
      end else if (EN) begin
         state <= nextState;
      end
   end

   // Next-state and action decode. In IDLE a key load wins over a start
   // request; in RUN all requests are ignored and the last round (one-hot
   // bit 9) returns the controller to IDLE.
   always_comb begin
      nextState = state;
      loadKey   = 1'b0;
      startEnc  = 1'b0;
      stepRound = 1'b0;
      lastRound = 1'b0;
      case (state)
         IDLE: begin
            if (Krdy) begin
               loadKey = 1'b1;
            end else if (Drdy) begin
               startEnc  = 1'b1;
               nextState = RUN;
            end
         end
         RUN: begin
            if (roundOneHot[9]) begin
               lastRound = 1'b1;
               nextState = IDLE;
            end else begin
               stepRound = 1'b1;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Datapath and key schedule registers. A start folds the initial
   // AddRoundKey into the load so round 1 runs on the very next edge. The
   // last round rewinds the round key to the cipher key so the next block
   // can start straight away.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         dataReg     <= '0;
         keyReg      <= '0;
         roundKeyReg <= '0;
         koutReg     <= '0;
         rcon        <= 8'h01;
         roundOneHot <= 10'd1;
         dvldReg     <= 1'b0;
         kvldReg     <= 1'b0;
      end else if (EN) begin
         if (loadKey) begin
            keyReg      <= Key;
            roundKeyReg <= Key;
            dvldReg     <= 1'b0;
            kvldReg     <= 1'b0;
         end
         if (startEnc) begin
            dataReg     <= Din ^ keyReg;
            roundKeyReg <= keyReg;
            rcon        <= 8'h01;
            roundOneHot <= 10'd1;
            dvldReg     <= 1'b0;
         end
         if (stepRound) begin
            dataReg     <= roundOut;
            roundKeyReg <= keyNext;
            rcon        <= xtime(rcon);
            roundOneHot <= {roundOneHot[8:0], 1'b0};
         end
         if (lastRound) begin
            dataReg     <= roundOut;
            roundKeyReg <= keyReg;
            rcon        <= 8'h01;
            roundOneHot <= 10'd1;
            dvldReg     <= 1'b1;
            if (KOUT_EN) begin
               koutReg <= keyNext;
               kvldReg <= 1'b1;
            end
         end
      end
   end

   assign Dout = dataReg;
   assign Dvld = dvldReg;
   assign BSY  = (state == RUN);
   assign Kout = koutReg;
   assign Kvld = kvldReg;

endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter
//    Self-checking bench for aes_enc_iter. Known-answer vectors and random
//    vectors are kept in a table and run through a load/start/wait sequence;
//    random expectations come from a byte-array AES-128 model whose S-box is
//    generated from the GF(2^8) inverse and affine map. Hand-written
//    sequences cover back-to-back blocks, ignored requests, EN stalls and
//    reset in the middle of an encryption.
module tb_aes_enc_iter;

   typedef struct {
      logic [127:0] key;
      logic [127:0] din;
      logic [127:0] expDout;
      logic [127:0] expKout;
   } vecT;

   logic         CLK = 1'b0;
   logic         RSTn;
   logic         EN;
   logic [127:0] Din;
   logic [127:0] Key;
   logic         Krdy;
   logic         Drdy;
   logic [127:0] Dout;
   logic         Dvld;
   logic         BSY;
   logic [127:0] Kout;
   logic         Kvld;

   int           compared = 0;
   int           mismatched = 0;
   logic [7:0]   sboxTab [256];
   vecT          vecs [8];

   aes_enc_iter #(.KOUT_EN(1'b1)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .EN   (EN),
      .Din  (Din),
      .Key  (Key),
      .Krdy (Krdy),
      .Drdy (Drdy),
      .Dout (Dout),
      .Dvld (Dvld),
      .BSY  (BSY),
      .Kout (Kout),
      .Kvld (Kvld)
   );

   // Free-running 10 time-unit clock.
   always #5 CLK = ~CLK;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = (v << n) | (v >> (8 - n));
      return r;
   endfunction

   // S-box from first principles: multiplicative inverse by search, then
   // the affine transform with constant 0x63.
   task automatic buildSbox();
      logic [7:0] inv;
      logic [7:0] xv;
      for (int x = 0; x < 256; x++) begin
         xv  = 8'(x);
         inv = 8'h00;
         for (int c = 1; c < 256; c++) begin
            if (gmul(xv, 8'(c)) == 8'h01) inv = 8'(c);
         end
         sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Reference AES-128: full 44-word key expansion up front, then ten rounds
   // on a 16-byte array, byte i being row i%4 of column i/4.
   task automatic modelEncrypt(input logic [127:0] key, input logic [127:0] pt,
                               output logic [127:0] ct, output logic [127:0] rk10);
      logic [31:0] w [44];
      logic [7:0]  st [16];
      logic [7:0]  tmp [16];
      logic [7:0]  rc;
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]], sboxTab[t[31:24]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) st[i] = sboxTab[st[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               tmp[row+4*c] = st[row+4*((c+row)%4)];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               st[4*c]   = gmul(tmp[4*c], 8'h02) ^ gmul(tmp[4*c+1], 8'h03) ^ tmp[4*c+2] ^ tmp[4*c+3];
               st[4*c+1] = tmp[4*c] ^ gmul(tmp[4*c+1], 8'h02) ^ gmul(tmp[4*c+2], 8'h03) ^ tmp[4*c+3];
               st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ gmul(tmp[4*c+2], 8'h02) ^ gmul(tmp[4*c+3], 8'h03);
               st[4*c+3] = gmul(tmp[4*c], 8'h03) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ gmul(tmp[4*c+3], 8'h02);
            end else begin
               for (int row = 0; row < 4; row++) st[4*c+row] = tmp[4*c+row];
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = st[i];
      rk10 = {w[40], w[41], w[42], w[43]};
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive the request inputs, then let one rising edge pass and settle.
   task automatic applyStimulus(input logic krdy, input logic drdy,
                                input logic [127:0] key, input logic [127:0] din);
      Krdy = krdy;
      Drdy = drdy;
      Key  = key;
      Din  = din;
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Idle edges until Dvld rises or the budget runs out; cycles counts edges
   // since the start edge.
   task automatic waitForDvld(inout int cycles, input int limit);
      while (!Dvld && cycles < limit) begin
         applyStimulus(1'b0, 1'b0, Key, Din);
         cycles++;
      end
   endtask

   task automatic runVector(input int idx, input vecT v);
      int cycles;
      applyStimulus(1'b1, 1'b0, v.key, v.din);
      checkOutput($sformatf("v%0d kvld after load", idx), {127'd0, Kvld}, 128'd0);
      applyStimulus(1'b0, 1'b1, v.key, v.din);
      checkOutput($sformatf("v%0d bsy after start", idx), {127'd0, BSY}, 128'd1);
      cycles = 0;
      waitForDvld(cycles, 40);
      checkOutput($sformatf("v%0d latency", idx), 128'(cycles), 128'd10);
      checkOutput($sformatf("v%0d dout", idx), Dout, v.expDout);
      checkOutput($sformatf("v%0d kout", idx), Kout, v.expKout);
      checkOutput($sformatf("v%0d kvld", idx), {127'd0, Kvld}, 128'd1);
      checkOutput($sformatf("v%0d bsy done", idx), {127'd0, BSY}, 128'd0);
   endtask

   initial begin
      logic [127:0] ctA, rkA, key2, pt2;
      int cycles;

      RSTn = 1'b0;
      EN   = 1'b1;
      Krdy = 1'b0;
      Drdy = 1'b0;
      Key  = '0;
      Din  = '0;
      buildSbox();

      vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5};
      for (int i = 2; i < 8; i++) begin
         vecs[i].key = rand128();
         vecs[i].din = rand128();
         modelEncrypt(vecs[i].key, vecs[i].din, vecs[i].expDout, vecs[i].expKout);
      end

      applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("reset bsy", {127'd0, BSY}, 128'd0);
      checkOutput("reset dvld", {127'd0, Dvld}, 128'd0);
      checkOutput("reset kvld", {127'd0, Kvld}, 128'd0);
      checkOutput("reset dout", Dout, 128'd0);
      checkOutput("reset kout", Kout, 128'd0);
      RSTn = 1'b1;

      $display("[TB] table vectors");
      for (int i = 0; i < 8; i++) runVector(i, vecs[i]);

      $display("[TB] back-to-back blocks with Drdy held");
      pt2 = vecs[2].din;
      modelEncrypt(vecs[0].key, pt2, ctA, rkA);
      applyStimulus(1'b1, 1'b0, vecs[0].key, vecs[0].din);
      applyStimulus(1'b0, 1'b1, vecs[0].key, vecs[0].din);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, vecs[0].key, pt2);
      checkOutput("b2b first dvld", {127'd0, Dvld}, 128'd1);
      checkOutput("b2b gap bsy", {127'd0, BSY}, 128'd0);
      checkOutput("b2b first dout", Dout, vecs[0].expDout);
      applyStimulus(1'b0, 1'b1, vecs[0].key, pt2);
      checkOutput("b2b restart bsy", {127'd0, BSY}, 128'd1);
      checkOutput("b2b restart dvld", {127'd0, Dvld}, 128'd0);
      cycles = 0;
      waitForDvld(cycles, 40);
      checkOutput("b2b second latency", 128'(cycles), 128'd10);
      checkOutput("b2b second dout", Dout, ctA);
      checkOutput("b2b kout", Kout, vecs[0].expKout);

      $display("[TB] requests while busy are dropped");
      key2 = vecs[3].key;
      applyStimulus(1'b1, 1'b0, vecs[0].key, vecs[0].din);
      applyStimulus(1'b0, 1'b1, vecs[0].key, vecs[0].din);
      cycles = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, vecs[0].key, vecs[0].din);
         cycles++;
      end
      applyStimulus(1'b1, 1'b1, key2, pt2);
      cycles++;
      waitForDvld(cycles, 40);
      checkOutput("busy-req latency", 128'(cycles), 128'd10);
      checkOutput("busy-req dout", Dout, vecs[0].expDout);
      checkOutput("busy-req kout", Kout, vecs[0].expKout);
      applyStimulus(1'b1, 1'b1, key2, vecs[0].din);
      checkOutput("both-req bsy", {127'd0, BSY}, 128'd0);
      checkOutput("both-req dvld", {127'd0, Dvld}, 128'd0);
      checkOutput("both-req kvld", {127'd0, Kvld}, 128'd0);
      checkOutput("both-req dout kept", Dout, vecs[0].expDout);
      applyStimulus(1'b0, 1'b0, key2, vecs[0].din);
      checkOutput("no queued start", {127'd0, BSY}, 128'd0);
      modelEncrypt(key2, vecs[0].din, ctA, rkA);
      applyStimulus(1'b0, 1'b1, vecs[0].key, vecs[0].din);
      cycles = 0;
      waitForDvld(cycles, 40);
      checkOutput("new key dout", Dout, ctA);
      checkOutput("new key kout", Kout, rkA);

      $display("[TB] EN stall mid-run");
      applyStimulus(1'b1, 1'b0, vecs[0].key, vecs[0].din);
      applyStimulus(1'b0, 1'b1, vecs[0].key, vecs[0].din);
      cycles = 0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, vecs[0].key, vecs[0].din);
         cycles++;
      end
      EN = 1'b0;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 1'b0, vecs[0].key, vecs[0].din);
         cycles++;
      end
      checkOutput("stall bsy", {127'd0, BSY}, 128'd1);
      checkOutput("stall dvld", {127'd0, Dvld}, 128'd0);
      EN = 1'b1;
      waitForDvld(cycles, 60);
      checkOutput("stall latency", 128'(cycles), 128'd17);
      checkOutput("stall dout", Dout, vecs[0].expDout);

      $display("[TB] reset mid-run");
      applyStimulus(1'b1, 1'b0, vecs[1].key, vecs[1].din);
      applyStimulus(1'b0, 1'b1, vecs[1].key, vecs[1].din);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, vecs[1].key, vecs[1].din);
      RSTn = 1'b0;
      applyStimulus(1'b0, 1'b0, vecs[1].key, vecs[1].din);
      checkOutput("midreset bsy", {127'd0, BSY}, 128'd0);
      checkOutput("midreset dvld", {127'd0, Dvld}, 128'd0);
      checkOutput("midreset kvld", {127'd0, Kvld}, 128'd0);
      checkOutput("midreset dout", Dout, 128'd0);
      RSTn = 1'b1;
      modelEncrypt(128'd0, vecs[1].din, ctA, rkA);
      applyStimulus(1'b0, 1'b1, vecs[1].key, vecs[1].din);
      cycles = 0;
      waitForDvld(cycles, 40);
      checkOutput("zero key dout", Dout, ctA);
      checkOutput("zero key kout", Kout, rkA);
      runVector(100, vecs[1]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
